// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for a five-stage MIPS-style pipeline.
// It arbitrates four events with the priority
//   memory freeze > taken branch > load-use > jump.
// A three-state FSM (RUN / MEM_WAIT / ERR) tracks outstanding data-memory
// accesses. If the memory never acknowledges, the FSM locks in ERR until reset.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. When it is undefined the counters are tied to zero.
//
// Parameters
//   MEM_TIMEOUT      maximum consecutive frozen cycles before ERR (2..255)
//
// Ports
//   i_clk, i_rst                  clock and synchronous active-high reset
//   i_IDEX_MemRead, i_IDEX_Rt     load instruction currently in EX
//   i_IFID_Rs, i_IFID_Rt          source registers of the instruction in ID
//   i_Jump, i_BranchTaken         jump decoded in ID, branch resolved taken
//   i_EXMEM_MemRead/MemWrite      memory access in MEM
//   i_MemAck                      that access completes this cycle
//   o_PCWrite..o_EXMEMWrite       pipeline-register write enables
//   o_IFID_Flush, o_IDEX_Bubble,
//   o_MEMWB_Bubble                zero the control fields of that register
//   o_PCSel                       00 PC+4, 01 branch target, 10 jump target
//   o_State                       FSM state (RUN=00, MEM_WAIT=01, ERR=10)
//   o_MemErr                      memory timeout occurred
//   o_StallCnt, o_FlushCnt        saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_IDEX_MemRead,
    input  logic [4:0]  i_IDEX_Rt,
    input  logic [4:0]  i_IFID_Rs,
    input  logic [4:0]  i_IFID_Rt,
    input  logic        i_Jump,
    input  logic        i_BranchTaken,
    input  logic        i_EXMEM_MemRead,
    input  logic        i_EXMEM_MemWrite,
    input  logic        i_MemAck,
    output logic        o_PCWrite,
    output logic        o_IFIDWrite,
    output logic        o_IDEXWrite,
    output logic        o_EXMEMWrite,
    output logic        o_IFID_Flush,
    output logic        o_IDEX_Bubble,
    output logic        o_MEMWB_Bubble,
    output logic [1:0]  o_PCSel,
    output logic [1:0]  o_State,
    output logic        o_MemErr,
    output logic [15:0] o_StallCnt,
    output logic [15:0] o_FlushCnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    // wait_cnt_q holds the number of frozen cycles already spent on the
    // current access. The MEM_WAIT cycle that sees wait_cnt_q == LAST_WAIT
    // is the MEM_TIMEOUT-th frozen cycle, so an unacknowledged access there
    // moves to ERR.
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    state_e     eff_state;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic mem_busy;
    logic load_use;
    logic frozen;
    logic run_events;
    logic err_out;

    assign mem_busy = (i_EXMEM_MemRead | i_EXMEM_MemWrite) & ~i_MemAck;
    assign load_use = i_IDEX_MemRead & (i_IDEX_Rt != 5'd0) &
                      ((i_IDEX_Rt == i_IFID_Rs) | (i_IDEX_Rt == i_IFID_Rt));

    // While reset is held, the outputs behave as if the FSM were in RUN.
    assign eff_state = i_rst ? RUN : state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        frozen     = 1'b0;
        run_events = 1'b0;
        err_out    = 1'b0;

        unique case (eff_state)
            RUN: begin
                if (mem_busy) begin
                    frozen     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    run_events = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!i_MemAck) begin
                    frozen = 1'b1;
                    if (wait_cnt_q == LAST_WAIT) begin
                        state_d = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // Ack cycle: the pipeline moves again, so the other
                    // events are arbitrated exactly as in RUN.
                    run_events = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            ERR: begin
                frozen  = 1'b1;
                err_out = 1'b1;
            end
            default: begin
                // Unused encoding: recover to RUN.
                run_events = 1'b1;
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Output decode. Lower-priority events are dropped rather than
    // remembered, because the held pipeline presents them again.
    always_comb begin
        o_PCWrite      = 1'b1;
        o_IFIDWrite    = 1'b1;
        o_IDEXWrite    = 1'b1;
        o_EXMEMWrite   = 1'b1;
        o_IFID_Flush   = 1'b0;
        o_IDEX_Bubble  = 1'b0;
        o_MEMWB_Bubble = 1'b0;
        o_PCSel        = 2'b00;

        if (frozen) begin
            o_PCWrite      = 1'b0;
            o_IFIDWrite    = 1'b0;
            o_IDEXWrite    = 1'b0;
            o_EXMEMWrite   = 1'b0;
            o_MEMWB_Bubble = 1'b1;
        end else if (run_events) begin
            if (i_BranchTaken) begin
                o_PCSel       = 2'b01;
                o_IFID_Flush  = 1'b1;
                o_IDEX_Bubble = 1'b1;
            end else if (load_use) begin
                o_PCWrite     = 1'b0;
                o_IFIDWrite   = 1'b0;
                o_IDEX_Bubble = 1'b1;
            end else if (i_Jump) begin
                o_PCSel      = 2'b10;
                o_IFID_Flush = 1'b1;
            end
        end
    end

    assign o_State  = eff_state;
    assign o_MemErr = err_out;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!o_PCWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (o_IFID_Flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_StallCnt = stall_cnt_q;
    assign o_FlushCnt = flush_cnt_q;
`else
    assign o_StallCnt = 16'd0;
    assign o_FlushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Bench for hazard_ctrl with MEM_TIMEOUT = 4. A behavioural model tracks
// "error latched", "access pending" and the length of the current freeze run.
// From those it derives every output on each falling edge. Directed phases pin
// the worked examples, and a randomized phase follows them. The expected
// counter values depend on whether HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int T = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_IDEX_MemRead;
    logic [4:0]  i_IDEX_Rt;
    logic [4:0]  i_IFID_Rs;
    logic [4:0]  i_IFID_Rt;
    logic        i_Jump;
    logic        i_BranchTaken;
    logic        i_EXMEM_MemRead;
    logic        i_EXMEM_MemWrite;
    logic        i_MemAck;
    logic        o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_EXMEMWrite;
    logic        o_IFID_Flush, o_IDEX_Bubble, o_MEMWB_Bubble;
    logic [1:0]  o_PCSel, o_State;
    logic        o_MemErr;
    logic [15:0] o_StallCnt, o_FlushCnt;

    hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_IDEX_MemRead   (i_IDEX_MemRead),
        .i_IDEX_Rt        (i_IDEX_Rt),
        .i_IFID_Rs        (i_IFID_Rs),
        .i_IFID_Rt        (i_IFID_Rt),
        .i_Jump           (i_Jump),
        .i_BranchTaken    (i_BranchTaken),
        .i_EXMEM_MemRead  (i_EXMEM_MemRead),
        .i_EXMEM_MemWrite (i_EXMEM_MemWrite),
        .i_MemAck         (i_MemAck),
        .o_PCWrite        (o_PCWrite),
        .o_IFIDWrite      (o_IFIDWrite),
        .o_IDEXWrite      (o_IDEXWrite),
        .o_EXMEMWrite     (o_EXMEMWrite),
        .o_IFID_Flush     (o_IFID_Flush),
        .o_IDEX_Bubble    (o_IDEX_Bubble),
        .o_MEMWB_Bubble   (o_MEMWB_Bubble),
        .o_PCSel          (o_PCSel),
        .o_State          (o_State),
        .o_MemErr         (o_MemErr),
        .o_StallCnt       (o_StallCnt),
        .o_FlushCnt       (o_FlushCnt)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_err = 0;      // timeout seen, waiting for reset
    bit m_wait = 0;     // an access was left pending by the last cycle
    int m_run = 0;      // consecutive frozen cycles so far
    int m_stall = 0;
    int m_flush = 0;
    bit n_err, n_wait;
    int n_run, n_stall, n_flush;

    bit e_frz, e_pcw, e_ifw, e_idw, e_emw, e_fl, e_bub, e_mwb, e_me;
    bit e_lu;
    logic [1:0] e_sel, e_st;
    logic [11:0] exp_vec, dut_vec;

    assign dut_vec = {o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_EXMEMWrite,
                      o_IFID_Flush, o_IDEX_Bubble, o_MEMWB_Bubble,
                      o_PCSel, o_State, o_MemErr};

    always @(negedge i_clk) begin
        if (started) begin
            e_me  = !i_rst && m_err;
            e_frz = e_me ||
                    (!i_rst && m_wait && !i_MemAck) ||
                    ((i_EXMEM_MemRead || i_EXMEM_MemWrite) && !i_MemAck);
            e_lu  = i_IDEX_MemRead && (i_IDEX_Rt != 0) &&
                    (i_IDEX_Rt == i_IFID_Rs || i_IDEX_Rt == i_IFID_Rt);
            {e_pcw, e_ifw, e_idw, e_emw} = 4'b1111;
            {e_fl, e_bub, e_mwb} = 3'b000;
            e_sel = 2'd0;
            if (e_frz) begin
                {e_pcw, e_ifw, e_idw, e_emw} = 4'b0000;
                e_mwb = 1;
            end else if (i_BranchTaken) begin
                e_sel = 2'd1; e_fl = 1; e_bub = 1;
            end else if (e_lu) begin
                e_pcw = 0; e_ifw = 0; e_bub = 1;
            end else if (i_Jump) begin
                e_sel = 2'd2; e_fl = 1;
            end
            e_st = i_rst ? 2'd0 : (m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0));
            exp_vec = {e_pcw, e_ifw, e_idw, e_emw, e_fl, e_bub, e_mwb, e_sel, e_st, e_me};
            check("outputs", 32'(dut_vec), 32'(exp_vec));
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cnt", 32'(o_StallCnt), m_stall);
            check("flush_cnt", 32'(o_FlushCnt), m_flush);
`else
            check("stall_cnt", 32'(o_StallCnt), 0);
            check("flush_cnt", 32'(o_FlushCnt), 0);
`endif
            // next model state
            if (i_rst) begin
                n_err = 0; n_wait = 0; n_run = 0; n_stall = 0; n_flush = 0;
            end else begin
                n_stall = (m_stall + (e_pcw ? 0 : 1) > 65535) ? 65535 : m_stall + (e_pcw ? 0 : 1);
                n_flush = (m_flush + (e_fl ? 1 : 0) > 65535) ? 65535 : m_flush + (e_fl ? 1 : 0);
                if (m_err) begin
                    n_err = 1; n_wait = 0; n_run = 0;
                end else if (e_frz) begin
                    n_run  = m_run + 1;
                    n_err  = (n_run == T);
                    n_wait = !n_err;
                end else begin
                    n_err = 0; n_wait = 0; n_run = 0;
                end
            end
        end
    end

    always @(posedge i_clk) begin
        if (started) begin
            m_err   <= n_err;
            m_wait  <= n_wait;
            m_run   <= n_run;
            m_stall <= n_stall;
            m_flush <= n_flush;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_IDEX_MemRead   = 0;
        i_IDEX_Rt        = 0;
        i_IFID_Rs        = 0;
        i_IFID_Rt        = 0;
        i_Jump           = 0;
        i_BranchTaken    = 0;
        i_EXMEM_MemRead  = 0;
        i_EXMEM_MemWrite = 0;
        i_MemAck         = 0;
    endtask

    task automatic do_reset();
        i_rst = 1;
        idle();
        step();
        started = 1;
        step();
        i_rst = 0;
    endtask

    task automatic randomize_inputs();
        i_IDEX_MemRead   = ($urandom_range(0, 99) < 40);
        i_IDEX_Rt        = 5'($urandom_range(0, 3));
        i_IFID_Rs        = 5'($urandom_range(0, 3));
        i_IFID_Rt        = 5'($urandom_range(0, 3));
        i_Jump           = ($urandom_range(0, 99) < 25);
        i_BranchTaken    = ($urandom_range(0, 99) < 15);
        i_EXMEM_MemRead  = ($urandom_range(0, 99) < 25);
        i_EXMEM_MemWrite = ($urandom_range(0, 99) < 15);
        i_MemAck         = ($urandom_range(0, 99) < 45);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1;
        idle();
        do_reset();

        // Reset state with idle inputs
        @(negedge i_clk);
        check("rst_state", 32'(o_State), 0);
        check("rst_pcwrite", 32'(o_PCWrite), 1);
        check("rst_stallcnt", 32'(o_StallCnt), 0);
        check("rst_flushcnt", 32'(o_FlushCnt), 0);

        // Load-use hazard on Rs
        step();
        i_IDEX_MemRead = 1; i_IDEX_Rt = 5; i_IFID_Rs = 5;
        @(negedge i_clk);
        check("lu_pcwrite", 32'(o_PCWrite), 0);
        check("lu_ifidwrite", 32'(o_IFIDWrite), 0);
        check("lu_bubble", 32'(o_IDEX_Bubble), 1);
        step();
        i_IDEX_Rt = 0; i_IFID_Rs = 0;
        @(negedge i_clk);
        check("lu_r0_pcwrite", 32'(o_PCWrite), 1);
        check("lu_r0_bubble", 32'(o_IDEX_Bubble), 0);

        // Branch + load-use + jump in the same cycle
        step();
        i_IDEX_Rt = 7; i_IFID_Rt = 7; i_Jump = 1; i_BranchTaken = 1;
        @(negedge i_clk);
        check("prio_pcsel", 32'(o_PCSel), 1);
        check("prio_flush", 32'(o_IFID_Flush), 1);
        check("prio_bubble", 32'(o_IDEX_Bubble), 1);
        check("prio_pcwrite", 32'(o_PCWrite), 1);

        // Ack on the 4th frozen cycle
        step();
        idle();
        i_EXMEM_MemRead = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("ack_frozen_en", 32'({o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_EXMEMWrite}), 0);
            check("ack_frozen_st", 32'(o_State), (c == 0) ? 0 : 1);
            step();
        end
        i_MemAck = 1;
        @(negedge i_clk);
        check("ack_cycle_en", 32'({o_PCWrite, o_IFIDWrite, o_IDEXWrite, o_EXMEMWrite}), 32'hF);
        step();
        idle();
        @(negedge i_clk);
        check("ack_after_st", 32'(o_State), 0);
        check("ack_after_err", 32'(o_MemErr), 0);

        // No ack at all: timeout into ERR
        step();
        i_EXMEM_MemRead = 1;
        for (int c = 0; c < T; c++) begin
            @(negedge i_clk);
            check("to_frozen_st", 32'(o_State), (c == 0) ? 0 : 1);
            check("to_frozen_err", 32'(o_MemErr), 0);
            step();
        end
        for (int c = 0; c < 10; c++) begin
            randomize_inputs();
            @(negedge i_clk);
            check("err_state", 32'(o_State), 2);
            check("err_memerr", 32'(o_MemErr), 1);
            check("err_pcwrite", 32'(o_PCWrite), 0);
            step();
        end
        do_reset();
        @(negedge i_clk);
        check("err_rst_state", 32'(o_State), 0);
        check("err_rst_memerr", 32'(o_MemErr), 0);

        // Reset in MEM_WAIT cycle 2, then the count restarts
        step();
        i_EXMEM_MemWrite = 1;
        step();
        step();
        i_rst = 1;
        step();
        i_rst = 0;
        @(negedge i_clk);
        check("mw_rst_state", 32'(o_State), 0);
        step();
        step();
        step();
        @(negedge i_clk);
        check("restart_4th_st", 32'(o_State), 1);
        step();
        @(negedge i_clk);
        check("restart_err_st", 32'(o_State), 2);
        do_reset();

        // 3 freeze + 1 load-use + 2 jump cycles for the counters
        i_EXMEM_MemRead = 1;
        step();
        step();
        step();
        i_MemAck = 1;
        step();
        idle();
        i_IDEX_MemRead = 1; i_IDEX_Rt = 3; i_IFID_Rt = 3;
        step();
        idle();
        i_Jump = 1;
        step();
        step();
        idle();
        @(negedge i_clk);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", 32'(o_StallCnt), 4);
        check("perf_flush", 32'(o_FlushCnt), 2);
`else
        check("perf_stall", 32'(o_StallCnt), 0);
        check("perf_flush", 32'(o_FlushCnt), 0);
`endif

        // Randomized phase against the model
        for (int c = 0; c < 2000; c++) begin
            step();
            randomize_inputs();
            i_rst = ($urandom_range(0, 99) < 2);
        end
        step();
        i_rst = 0;
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
